// File: rtl/muldiv_unit.sv
// HI/LO multiply-divide unit for the E stage.
// Fixed-latency MULT/MULTU/DIV/DIVU plus direct MTHI/MTLO writes.
module muldiv_unit #(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [3:0]  cnt;
    logic [3:0]  cnt_nx;
    logic [2:0]  op_q;
    logic [2:0]  op_nx;
    logic [31:0] a_q;
    logic [31:0] a_nx;
    logic [31:0] b_q;
    logic [31:0] b_nx;
    logic [31:0] hi_nx;
    logic [31:0] lo_nx;

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        a_neg;
    logic        b_neg;
    logic        b_zero;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] b_safe;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quo;
    logic [31:0] rem;

    // Result datapath works on the latched operands; only sampled at commit.
    always_comb begin
        prod_u = {32'd0, a_q} * {32'd0, b_q};
        prod_s = $signed({{32{a_q[31]}}, a_q})
               * $signed({{32{b_q[31]}}, b_q});
    end

    // Signed divide via magnitudes: MIN/-1 wraps naturally to MIN, rem 0.
    always_comb begin
        a_neg  = (op_q == OP_DIV) && a_q[31];
        b_neg  = (op_q == OP_DIV) && b_q[31];
        b_zero = (b_q == 32'd0);
        a_mag  = a_neg ? (~a_q + 32'd1) : a_q;
        b_mag  = b_neg ? (~b_q + 32'd1) : b_q;
        b_safe = b_zero ? 32'd1 : b_mag;
        q_mag  = a_mag / b_safe;
        r_mag  = a_mag % b_safe;
        quo    = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
        rem    = a_neg ? (~r_mag + 32'd1) : r_mag;
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        op_nx    = op_q;
        a_nx     = a_q;
        b_nx     = b_q;
        hi_nx    = hi;
        lo_nx    = lo;
        unique case (state)
            IDLE: begin
                if (start) begin
                    unique case (op)
                        OP_MULT, OP_MULTU: begin
                            state_nx = RUN;
                            cnt_nx   = 4'(MUL_LAT);
                            op_nx    = op;
                            a_nx     = rs_val;
                            b_nx     = rt_val;
                        end
                        OP_DIV, OP_DIVU: begin
                            state_nx = RUN;
                            cnt_nx   = 4'(DIV_LAT);
                            op_nx    = op;
                            a_nx     = rs_val;
                            b_nx     = rt_val;
                        end
                        OP_MTHI: hi_nx = rs_val;
                        OP_MTLO: lo_nx = rs_val;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                cnt_nx = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_nx = IDLE;
                    unique case (op_q)
                        OP_MULT:  {hi_nx, lo_nx} = prod_s;
                        OP_MULTU: {hi_nx, lo_nx} = prod_u;
                        OP_DIV, OP_DIVU: begin
                            if (!b_zero) begin
                                hi_nx = rem;
                                lo_nx = quo;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
            op_q  <= 3'd0;
            a_q   <= 32'd0;
            b_q   <= 32'd0;
            hi    <= 32'd0;
            lo    <= 32'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            op_q  <= op_nx;
            a_q   <= a_nx;
            b_q   <= b_nx;
            hi    <= hi_nx;
            lo    <= lo_nx;
        end
    end

    assign busy = (state == RUN);

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit with a plain-arithmetic reference model.
// Commits are checked by a separate monitor watching busy fall.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] rs_val = 32'd0;
    logic [31:0] rt_val = 32'd0;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    muldiv_unit #(.MUL_LAT(5), .DIV_LAT(10)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
        string       name;
    } exp_t;

    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Architectural model: what HI/LO hold after the op, and its busy length.
    task automatic predict(input logic [2:0] o, input logic [31:0] a,
                           input logic [31:0] b, output exp_t e);
        int          sa;
        int          sb;
        longint      p;
        longint      q;
        longint      r;
        logic [63:0] pu;
        sa    = a;
        sb    = b;
        e.hi  = m_hi;
        e.lo  = m_lo;
        e.lat = 0;
        case (o)
            3'd0: begin
                p = longint'(sa) * longint'(sb);
                e.hi = p[63:32];
                e.lo = p[31:0];
                e.lat = 5;
            end
            3'd1: begin
                pu = 64'(a) * 64'(b);
                e.hi = pu[63:32];
                e.lo = pu[31:0];
                e.lat = 5;
            end
            3'd2: begin
                if (b != 0) begin
                    q = longint'(sa) / longint'(sb);
                    r = longint'(sa) % longint'(sb);
                    e.lo = q[31:0];
                    e.hi = r[31:0];
                end
                e.lat = 10;
            end
            3'd3: begin
                if (b != 0) begin
                    e.lo = a / b;
                    e.hi = a % b;
                end
                e.lat = 10;
            end
            3'd4: e.hi = a;
            3'd5: e.lo = a;
            default: ;
        endcase
        m_hi = e.hi;
        m_lo = e.lo;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (busy !== 1'b0)
            chk({name, " timeout"}, 64'(busy), 64'd0);
    endtask

    task automatic run_op(input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input string name);
        exp_t e;
        predict(o, a, b, e);
        e.name = name;
        @(negedge clk);
        chk({name, " idle"}, 64'(busy), 64'd0);
        start  = 1'b1;
        op     = o;
        rs_val = a;
        rt_val = b;
        if (e.lat > 0)
            exp_q.push_back(e);
        @(negedge clk);
        start  = 1'b0;
        rs_val = $urandom;
        rt_val = $urandom;
        if (e.lat == 0) begin
            chk({name, " busy"}, 64'(busy), 64'd0);
            chk({name, " hi"}, 64'(hi), 64'(e.hi));
            chk({name, " lo"}, 64'(lo), 64'(e.lo));
        end else begin
            wait_idle(name);
        end
    endtask

    initial begin : monitor
        int   run;
        bit   prev;
        exp_t e;
        run  = 0;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                run  = 0;
                prev = 1'b0;
            end else if (busy === 1'b1) begin
                run++;
                prev = 1'b1;
            end else if (prev) begin
                prev = 1'b0;
                if (exp_q.size() == 0) begin
                    chk("unexpected commit", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk({e.name, " latency"}, 64'(run), 64'(e.lat));
                    chk({e.name, " hi"}, 64'(hi), 64'(e.hi));
                    chk({e.name, " lo"}, 64'(lo), 64'(e.lo));
                end
                run = 0;
            end
        end
    end

    initial begin : driver
        exp_t        e;
        logic [2:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        repeat (3) @(negedge clk);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset hi", 64'(hi), 64'd0);
        chk("reset lo", 64'(lo), 64'd0);
        reset = 1'b1;

        run_op(3'd0, 32'hFFFFFFFE, 32'd3, "mult -2*3");
        run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu max");
        run_op(3'd2, 32'hFFFFFFF9, 32'd2, "div -7/2");
        run_op(3'd3, 32'd7, 32'd2, "divu 7/2");
        run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, "div min/-1");
        run_op(3'd4, 32'h11, 32'd0, "mthi 11");
        run_op(3'd5, 32'h22, 32'd0, "mtlo 22");
        run_op(3'd3, 32'd5, 32'd0, "divu by 0");
        run_op(3'd2, 32'hFFFFFFF0, 32'd0, "div by 0");
        run_op(3'd4, 32'hDEADBEEF, 32'd0, "mthi deadbeef");
        run_op(3'd6, 32'h55, 32'h66, "nop6");
        run_op(3'd7, 32'h77, 32'h88, "nop7");

        // Starts during RUN and in the commit cycle must both be dropped.
        predict(3'd0, 32'h1234, 32'h5678, e);
        e.name = "mult restart";
        @(negedge clk);
        start  = 1'b1;
        op     = 3'd0;
        rs_val = 32'h1234;
        rt_val = 32'h5678;
        exp_q.push_back(e);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            start  = (i == 2) || (i == 5);
            op     = (i == 2) ? 3'd3 : 3'd4;
            rs_val = 32'hAAAA0000 + 32'(i);
            rt_val = 32'd7;
        end
        start = 1'b0;
        @(negedge clk);
        chk("commit-cycle start busy", 64'(busy), 64'd0);
        chk("commit-cycle start hi", 64'(hi), 64'(m_hi));
        chk("commit-cycle start lo", 64'(lo), 64'(m_lo));

        // Reset on busy cycle 3 aborts; reset beats a simultaneous start.
        @(negedge clk);
        start  = 1'b1;
        op     = 3'd0;
        rs_val = 32'd5;
        rt_val = 32'd7;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("abort busy", 64'(busy), 64'd0);
        chk("abort hi", 64'(hi), 64'd0);
        chk("abort lo", 64'(lo), 64'd0);
        start  = 1'b1;
        op     = 3'd4;
        rs_val = 32'h1234;
        @(negedge clk);
        chk("reset priority hi", 64'(hi), 64'd0);
        chk("reset priority busy", 64'(busy), 64'd0);
        reset = 1'b1;
        start = 1'b0;
        m_hi  = 32'd0;
        m_lo  = 32'd0;

        for (int k = 0; k < 40; k++) begin
            o = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 4))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: begin
                    a = 32'h80000000;
                    b = 32'hFFFFFFFF;
                end
                3: a = 32'($urandom_range(0, 100));
                default: ;
            endcase
            run_op(o, a, b, $sformatf("rnd%0d op%0d", k, o));
        end

        repeat (3) @(negedge clk);
        chk("scoreboard drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-low.
REQ-002 SHALL have port clk  in  1  rising-edge clock for all state.
REQ-003 SHALL have port reset  in  1  synchronous active-low reset, sampled on clk rising edge.
REQ-004 SHALL have port start  in  1  one-cycle request from the E stage; ignored while busy=1.
REQ-005 SHALL have port op  in  3  operation code: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op.
REQ-006 SHALL have port rs_val  in  32  forwarded rs operand, sampled with start.
REQ-007 SHALL have port rt_val  in  32  forwarded rt operand, sampled with start.
REQ-008 SHALL have port busy  out  1  operation in flight; the D stage stalls any HI/LO instruction while busy=1 or start=1.
REQ-009 SHALL have port hi  out  32  architectural HI register.
REQ-010 SHALL have port lo  out  32  architectural LO register.
REQ-011 SHALL have parameter MUL_LAT, default 5, meaning busy cycles for MULT/MULTU.
REQ-012 SHALL have parameter DIV_LAT, default 10, meaning busy cycles for DIV/DIVU.

Function
REQ-013 SHALL define states IDLE and RUN, with a down-counter cnt of 4 bits.
REQ-014 SHALL go IDLE->RUN on start=1 with op 0-3, loading cnt with MUL_LAT or DIV_LAT and latching the operands and op.
REQ-015 SHALL drive busy=1 from the first edge after start through exactly MUL_LAT or DIV_LAT cycles; busy is low in the start cycle itself.
REQ-016 SHALL decrement cnt once per cycle in RUN; at cnt=1 the next edge commits the result to hi and lo, sets busy=0 and returns to IDLE.
REQ-017 SHALL hold hi and lo at their old values during RUN; the result is visible only after commit.
REQ-018 SHALL compute MULT as the signed 64-bit product rs*rt, with hi = bits 63:32 and lo = bits 31:0.
REQ-019 SHALL compute MULTU as the unsigned 64-bit product, split the same way as MULT.
REQ-020 SHALL compute DIV with lo = quotient truncated toward zero and hi = remainder carrying the dividend's sign.
REQ-021 SHALL give DIV 0x80000000 / 0xFFFFFFFF the result lo=0x80000000, hi=0.
REQ-022 SHALL compute DIVU with lo = unsigned quotient and hi = unsigned remainder.
REQ-023 SHALL, for DIV or DIVU with rt_val=0, run the full DIV_LAT busy period and leave hi and lo unchanged at commit.
REQ-024 SHALL, for MTHI/MTLO with start=1 in IDLE, write rs_val to hi/lo at the next edge, keep busy=0, and stay in IDLE.
REQ-025 SHALL, for op 6-7, have no effect.
REQ-026 SHALL ignore start=1 in RUN (no restart, operands not relatched); the pipeline guarantees this does not occur.
REQ-027 SHALL let start=1 in the same cycle as commit be accepted only on the following IDLE cycle; that start is therefore ignored.
REQ-028 SHALL permit, but need not use, a multi-cycle iterative datapath, provided the latencies and results above are met exactly.

Reset
REQ-029 SHALL, on reset=0 at a clk edge, set state=IDLE, cnt=0, busy=0, hi=0, lo=0 and clear the latched operands.
REQ-030 SHALL, on reset mid-RUN, abort the operation with no commit; the outputs become the reset values at that edge.
REQ-031 SHALL make reset take priority over start in the same cycle.

Verification
REQ-032 SHALL test: MULT rs=0xFFFFFFFE (-2), rt=3 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-033 SHALL test: MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 after 5 busy cycles.
REQ-034 SHALL test: DIV rs=0xFFFFFFF9 (-7), rt=2 -> busy 10 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/2 -> lo=3, hi=1.
REQ-035 SHALL test: DIVU rt=0 with hi=0x11, lo=0x22 preloaded by MTHI/MTLO -> busy 10 cycles, hi=0x11, lo=0x22 unchanged.
REQ-036 SHALL test: MTHI rs=0xDEADBEEF -> hi=0xDEADBEEF one edge later, busy never 1.
REQ-037 SHALL test: MULT started, then reset=0 on busy cycle 3 -> busy=0, hi=lo=0 next edge; a second start during busy shows no effect on result or latency.
